// File: rtl/mccpu_ctrl_if.sv
// Control bus between the multi-cycle MIPS main controller and its datapath.
//   opcode/funct : IR fields decoded by the controller
//   zero         : registered ALU zero flag
//   PCWrite..ALUOp : datapath write enables and mux selects
//   state        : current controller phase (0 IF, 1 ID, 2 EXE, 3 MEM, 4 WB)
//   instr_cnt    : retired-instruction count, CNT_W bits wide
// master = controller side, slave = datapath side.
interface mccpu_ctrl_if #(parameter int CNT_W = 32);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             PCWrite;
   logic [1:0]       NPCOp;
   logic             IorD;
   logic             MemWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic [1:0]       GPRSel;
   logic [1:0]       WDSel;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [3:0]       ALUOp;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_cnt;

   modport master (
      input  opcode, funct, zero,
      output PCWrite, NPCOp, IorD, MemWrite, IRWrite, RegWrite,
             GPRSel, WDSel, ALUSrcA, ALUSrcB, ALUOp, state, instr_cnt
   );

   modport slave (
      output opcode, funct, zero,
      input  PCWrite, NPCOp, IorD, MemWrite, IRWrite, RegWrite,
             GPRSel, WDSel, ALUSrcA, ALUSrcB, ALUOp, state, instr_cnt
   );
endinterface

// File: rtl/mccpu_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU (shared instruction/data memory).
// Walks IF/ID/EXE/MEM/WB, decoding opcode/funct into datapath selects and write
// enables, and counts retired instructions.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : mccpu_ctrl_if.master (decode inputs, control outputs, state, instr_cnt)
module mccpu_ctrl #(
   parameter int CNT_W = 32
) (
   input logic          clk,
   input logic          rstn,
   mccpu_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR  = 4'd3,
      A_XOR = 4'd4, A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7,
      A_SLL = 4'd8, A_SRL = 4'd9, A_SRA = 4'd10, A_LUI = 4'd11
   } alu_op_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;

   logic    is_r, r_alu, r_sh, r_jr;
   logic    i_alu, op_lw, op_sw, op_beq, op_bne, op_j, op_jal, legal;
   alu_op_t r_op, i_op;
   logic [1:0] i_srcb;

   always_comb begin
      is_r   = (bus.opcode == 6'h00);
      op_j   = (bus.opcode == 6'h02);
      op_jal = (bus.opcode == 6'h03);
      op_beq = (bus.opcode == 6'h04);
      op_bne = (bus.opcode == 6'h05);
      op_lw  = (bus.opcode == 6'h23);
      op_sw  = (bus.opcode == 6'h2B);
      r_jr   = is_r && (bus.funct == 6'h08);
      r_sh   = is_r && (bus.funct == 6'h00 || bus.funct == 6'h02 || bus.funct == 6'h03);

      r_alu = is_r;
      r_op  = A_ADD;
      case (bus.funct)
         6'h20, 6'h21: r_op = A_ADD;
         6'h22, 6'h23: r_op = A_SUB;
         6'h24:        r_op = A_AND;
         6'h25:        r_op = A_OR;
         6'h26:        r_op = A_XOR;
         6'h27:        r_op = A_NOR;
         6'h2A:        r_op = A_SLT;
         6'h2B:        r_op = A_SLTU;
         6'h00:        r_op = A_SLL;
         6'h02:        r_op = A_SRL;
         6'h03:        r_op = A_SRA;
         default:      r_alu = 1'b0;
      endcase
      r_alu = r_alu && !r_sh;

      i_alu  = 1'b1;
      i_op   = A_ADD;
      i_srcb = 2'b11;
      case (bus.opcode)
         6'h08, 6'h09: begin i_op = A_ADD; i_srcb = 2'b10; end
         6'h0A:        begin i_op = A_SLT; i_srcb = 2'b10; end
         6'h0C:        i_op = A_AND;
         6'h0D:        i_op = A_OR;
         6'h0E:        i_op = A_XOR;
         6'h0F:        i_op = A_LUI;
         default:      i_alu = 1'b0;
      endcase

      legal = r_alu || r_sh || r_jr || i_alu || op_lw || op_sw ||
              op_beq || op_bne || op_j || op_jal;
   end

   always_comb begin
      state_d      = S_IF;
      bus.PCWrite  = 1'b0;
      bus.NPCOp    = 2'b00;
      bus.IorD     = 1'b0;
      bus.MemWrite = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.GPRSel   = 2'b00;
      bus.WDSel    = 2'b00;
      bus.ALUSrcA  = 2'b00;
      bus.ALUSrcB  = 2'b00;
      bus.ALUOp    = A_ADD;

      case (state_q)
         S_IF: begin
            bus.IRWrite = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.PCWrite = 1'b1;
            state_d     = S_ID;
         end
         S_ID: begin
            if (op_j || op_jal) begin
               bus.PCWrite = 1'b1;
               bus.NPCOp   = 2'b10;
               if (op_jal) begin
                  bus.RegWrite = 1'b1;
                  bus.GPRSel   = 2'b10;
                  bus.WDSel    = 2'b10;
               end
            end else if (r_jr) begin
               bus.PCWrite = 1'b1;
               bus.NPCOp   = 2'b11;
            end else if (legal) begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            bus.ALUSrcA = 2'b01;
            if (is_r) begin
               bus.ALUOp = r_op;
               if (r_sh) bus.ALUSrcA = 2'b10;
               state_d = S_WB;
            end else if (i_alu) begin
               bus.ALUOp   = i_op;
               bus.ALUSrcB = i_srcb;
               state_d     = S_WB;
            end else if (op_lw || op_sw) begin
               bus.ALUSrcB = 2'b10;
               state_d     = S_MEM;
            end else begin
               // beq/bne: PC loads the branch target only when the condition holds
               bus.ALUOp   = A_SUB;
               bus.NPCOp   = 2'b01;
               bus.PCWrite = op_beq ? bus.zero : !bus.zero;
            end
         end
         S_MEM: begin
            bus.IorD = 1'b1;
            if (op_sw) bus.MemWrite = 1'b1;
            else       state_d = S_WB;
         end
         S_WB: begin
            bus.RegWrite = 1'b1;
            if (op_lw) begin
               bus.WDSel  = 2'b01;
               bus.GPRSel = 2'b01;
            end else if (!is_r) begin
               bus.GPRSel = 2'b01;
            end
         end
         default: state_d = S_IF;
      endcase

      // Outputs are combinational, so holding reset must also mask them directly.
      if (!rstn) begin
         bus.PCWrite  = 1'b0;
         bus.NPCOp    = 2'b00;
         bus.IorD     = 1'b0;
         bus.MemWrite = 1'b0;
         bus.IRWrite  = 1'b0;
         bus.RegWrite = 1'b0;
         bus.GPRSel   = 2'b00;
         bus.WDSel    = 2'b00;
         bus.ALUSrcA  = 2'b00;
         bus.ALUSrcB  = 2'b00;
         bus.ALUOp    = A_ADD;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q != S_IF && state_d == S_IF) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.state     = state_q;
   assign bus.instr_cnt = cnt_q;

endmodule
